// File: rtl/scalar_branch_unit_pkg.sv
// Shared types and defaults for the scalar branch unit.
package scalar_branch_unit_pkg;

  localparam int unsigned BRU_ADDR_W = 36;
  localparam int unsigned BRU_CNT_W  = 32;

  typedef enum logic [2:0] {
    COND_NE     = 3'b000,
    COND_EQ     = 3'b001,
    COND_GT     = 3'b010,
    COND_LT     = 3'b011,
    COND_GE     = 3'b100,
    COND_LE     = 3'b101,
    COND_OV     = 3'b110,
    COND_ALWAYS = 3'b111
  } cond_e;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_REDIRECT = 1'b1
  } bru_state_e;

  typedef struct packed {
    logic z;
    logic s;
    logic v;
  } flags_t;

endpackage

// File: rtl/scalar_branch_unit_if.sv
// Execute/fetch-side signal bundle of the scalar branch unit.
interface scalar_branch_unit_if #(
  parameter int unsigned ADDR_W = scalar_branch_unit_pkg::BRU_ADDR_W,
  parameter int unsigned CNT_W  = scalar_branch_unit_pkg::BRU_CNT_W
);

  // Execute-stage results
  logic              flags_valid;
  logic              set_flags;
  logic              zero;
  logic              sign;
  logic              overflow;
  logic              branch_valid;
  logic [2:0]        branch_cond;
  logic [ADDR_W-1:0] branch_target;

  // Fetch redirect handshake
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              redirect_ready;

  // Pipeline control and status
  logic              stall;
  logic              squash;
  logic              flag_z;
  logic              flag_s;
  logic              flag_v;
  logic [CNT_W-1:0]  branch_count;
  logic [CNT_W-1:0]  taken_count;

  // Environment side (execute + fetch)
  modport master (
    output flags_valid, set_flags, zero, sign, overflow,
    output branch_valid, branch_cond, branch_target, redirect_ready,
    input  redirect_valid, redirect_pc, stall, squash,
    input  flag_z, flag_s, flag_v, branch_count, taken_count
  );

  // Branch unit side
  modport slave (
    input  flags_valid, set_flags, zero, sign, overflow,
    input  branch_valid, branch_cond, branch_target, redirect_ready,
    output redirect_valid, redirect_pc, stall, squash,
    output flag_z, flag_s, flag_v, branch_count, taken_count
  );

endinterface

// File: rtl/scalar_branch_unit_cond_eval.sv
// Combinational condition-code evaluation against Z/S/V flags.
module branch_cond_eval
  import scalar_branch_unit_pkg::*;
(
  input  cond_e cond_i,
  input  logic  z_i,
  input  logic  s_i,
  input  logic  v_i,
  output logic  taken_o
);

  // Decode the condition code into a taken decision
  always_comb begin
    taken_o = 1'b0;
    unique case (cond_i)
      COND_NE:     taken_o = !z_i;
      COND_EQ:     taken_o = z_i;
      COND_GT:     taken_o = !z_i && (s_i == v_i);
      COND_LT:     taken_o = (s_i != v_i);
      COND_GE:     taken_o = (s_i == v_i);
      COND_LE:     taken_o = z_i || (s_i != v_i);
      COND_OV:     taken_o = v_i;
      COND_ALWAYS: taken_o = 1'b1;
      default:     taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/scalar_branch_unit.sv
// Scalar branch unit: architectural flag register, branch resolution,
// fetch redirect handshake with issue stall/squash, and statistics counters.
module scalar_branch_unit
  import scalar_branch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = BRU_ADDR_W,
  parameter int unsigned CNT_W  = BRU_CNT_W
) (
  input logic                 clk,
  input logic                 rst,
  scalar_branch_unit_if.slave bus
);

  bru_state_e        state_q;
  logic              redirect_valid_q;
  logic              stall_q;
  logic [ADDR_W-1:0] redirect_pc_q;

  flags_t            flags_q, flags_d;
  flags_t            flags_in;
  flags_t            flags_eff;
  logic [CNT_W-1:0]  branch_count_q, branch_count_d;
  logic [CNT_W-1:0]  taken_count_q, taken_count_d;

  logic              flag_wr;
  logic              cond_taken;
  logic              in_idle;
  logic              handshake;

  assign in_idle   = (state_q == ST_IDLE);
  assign flag_wr   = bus.flags_valid && bus.set_flags;
  assign flags_in  = '{z: bus.zero, s: bus.sign, v: bus.overflow};
  // A same-cycle flag write comes from an older instruction, so it is
  // bypassed ahead of the architectural copy.
  assign flags_eff = flag_wr ? flags_in : flags_q;
  assign handshake = redirect_valid_q && bus.redirect_ready;

  branch_cond_eval u_cond_eval (
    .cond_i  (cond_e'(bus.branch_cond)),
    .z_i     (flags_eff.z),
    .s_i     (flags_eff.s),
    .v_i     (flags_eff.v),
    .taken_o (cond_taken)
  );

  // Flag register and counter next-state; everything is frozen in REDIRECT
  always_comb begin
    flags_d        = flags_q;
    branch_count_d = branch_count_q;
    taken_count_d  = taken_count_q;
    if (in_idle) begin
      if (flag_wr) begin
        flags_d = flags_in;
      end
      if (bus.branch_valid) begin
        branch_count_d = branch_count_q + CNT_W'(1);
        if (cond_taken) begin
          taken_count_d = taken_count_q + CNT_W'(1);
        end
      end
    end
  end

  // Flag register and statistics counters
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q        <= '0;
      branch_count_q <= '0;
      taken_count_q  <= '0;
    end else begin
      flags_q        <= flags_d;
      branch_count_q <= branch_count_d;
      taken_count_q  <= taken_count_d;
    end
  end

  // Redirect FSM with registered valid/stall/target outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      redirect_valid_q <= 1'b0;
      stall_q          <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.branch_valid && cond_taken) begin
            state_q          <= ST_REDIRECT;
            redirect_valid_q <= 1'b1;
            stall_q          <= 1'b1;
            redirect_pc_q    <= bus.branch_target;
          end
        end
        ST_REDIRECT: begin
          if (handshake) begin
            state_q          <= ST_IDLE;
            redirect_valid_q <= 1'b0;
            stall_q          <= 1'b0;
          end
        end
        default: begin
          state_q          <= ST_IDLE;
          redirect_valid_q <= 1'b0;
          stall_q          <= 1'b0;
        end
      endcase
    end
  end

  assign bus.redirect_valid = redirect_valid_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.stall          = stall_q;
  // Reset wins over an in-flight handshake, so no flush is signalled then.
  assign bus.squash         = handshake && !rst;
  assign bus.flag_z         = flags_q.z;
  assign bus.flag_s         = flags_q.s;
  assign bus.flag_v         = flags_q.v;
  assign bus.branch_count   = branch_count_q;
  assign bus.taken_count    = taken_count_q;

endmodule

// File: tb/tb_scalar_branch_unit.sv
// Directed self-checking bench for scalar_branch_unit.
module tb_scalar_branch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  scalar_branch_unit_if #(.ADDR_W(36), .CNT_W(32)) bus0 ();
  scalar_branch_unit_if #(.ADDR_W(36), .CNT_W(4))  bus1 ();

  scalar_branch_unit #(.ADDR_W(36), .CNT_W(32)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  scalar_branch_unit #(.ADDR_W(36), .CNT_W(4)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Hand-computed taken table: golden[cond][{z,s,v}]
  logic [7:0] golden [8] = '{8'h0F, 8'hF0, 8'h09, 8'h66, 8'h99, 8'hF6, 8'hAA, 8'hFF};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus0.flags_valid = 0; bus0.set_flags = 0; bus0.zero = 0; bus0.sign = 0; bus0.overflow = 0;
    bus0.branch_valid = 0; bus0.branch_cond = 3'd0; bus0.branch_target = '0; bus0.redirect_ready = 0;
    bus1.flags_valid = 0; bus1.set_flags = 0; bus1.zero = 0; bus1.sign = 0; bus1.overflow = 0;
    bus1.branch_valid = 0; bus1.branch_cond = 3'd0; bus1.branch_target = '0; bus1.redirect_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_inputs();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({bus0.redirect_valid, bus0.stall, bus0.squash, bus0.flag_z, bus0.flag_s, bus0.flag_v} !== 6'b0) begin
      n_mis++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {bus0.redirect_valid, bus0.stall, bus0.squash, bus0.flag_z, bus0.flag_s, bus0.flag_v});
    end
    n_cmp++;
    if (bus0.redirect_pc !== 36'h0) begin
      n_mis++; $display("FAIL reset_pc: got %h want 0", bus0.redirect_pc);
    end
    n_cmp++;
    if (bus0.branch_count !== 32'd0 || bus0.taken_count !== 32'd0) begin
      n_mis++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", bus0.branch_count, bus0.taken_count);
    end
    n_cmp++;
    if (bus1.branch_count !== 4'd0 || bus1.taken_count !== 4'd0 || bus1.redirect_valid !== 1'b0) begin
      n_mis++; $display("FAIL reset_dut1: got %0d/%0d rv=%b want 0/0 rv=0",
                        bus1.branch_count, bus1.taken_count, bus1.redirect_valid);
    end
  endtask

  task automatic test_bypass();
    do_reset();
    bus0.flags_valid = 1; bus0.set_flags = 1; bus0.zero = 1;
    bus0.branch_valid = 1; bus0.branch_cond = 3'b001; bus0.branch_target = 36'h000001000;
    step();
    clear_inputs();
    #1;
    n_cmp++;
    if ({bus0.redirect_valid, bus0.stall, bus0.squash} !== 3'b110) begin
      n_mis++; $display("FAIL bypass_ctrl: got %b want 110", {bus0.redirect_valid, bus0.stall, bus0.squash});
    end
    n_cmp++;
    if (bus0.redirect_pc !== 36'h000001000) begin
      n_mis++; $display("FAIL bypass_pc: got %h want 000001000", bus0.redirect_pc);
    end
    n_cmp++;
    if ({bus0.flag_z, bus0.flag_s, bus0.flag_v} !== 3'b100) begin
      n_mis++; $display("FAIL bypass_flags: got %b want 100", {bus0.flag_z, bus0.flag_s, bus0.flag_v});
    end
    bus0.redirect_ready = 1;
    #1;
    n_cmp++;
    if (bus0.squash !== 1'b1) begin
      n_mis++; $display("FAIL bypass_squash: got %b want 1", bus0.squash);
    end
    step();
    bus0.redirect_ready = 0;
    #1;
    n_cmp++;
    if ({bus0.redirect_valid, bus0.stall, bus0.squash} !== 3'b000) begin
      n_mis++; $display("FAIL bypass_idle: got %b want 000", {bus0.redirect_valid, bus0.stall, bus0.squash});
    end
    n_cmp++;
    if (bus0.branch_count !== 32'd1 || bus0.taken_count !== 32'd1) begin
      n_mis++; $display("FAIL bypass_cnt: got %0d/%0d want 1/1", bus0.branch_count, bus0.taken_count);
    end
  endtask

  task automatic test_not_taken();
    do_reset();
    bus0.flags_valid = 1; bus0.set_flags = 1; bus0.zero = 0; bus0.sign = 1; bus0.overflow = 0;
    step();
    clear_inputs();
    bus0.branch_valid = 1; bus0.branch_cond = 3'b100; bus0.branch_target = 36'h000002000;
    step();
    clear_inputs();
    #1;
    n_cmp++;
    if (bus0.redirect_valid !== 1'b0 || bus0.stall !== 1'b0) begin
      n_mis++; $display("FAIL nt_redirect: got rv=%b stall=%b want 0 0", bus0.redirect_valid, bus0.stall);
    end
    n_cmp++;
    if (bus0.branch_count !== 32'd1 || bus0.taken_count !== 32'd0) begin
      n_mis++; $display("FAIL nt_cnt: got %0d/%0d want 1/0", bus0.branch_count, bus0.taken_count);
    end
    n_cmp++;
    if ({bus0.flag_z, bus0.flag_s, bus0.flag_v} !== 3'b010) begin
      n_mis++; $display("FAIL nt_flags: got %b want 010", {bus0.flag_z, bus0.flag_s, bus0.flag_v});
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus0.branch_valid = 1; bus0.branch_cond = 3'b111; bus0.branch_target = 36'hABCDE0123;
    step();
    for (int i = 0; i < 3; i++) begin
      // Wrong-path flag writes and branches while fetch is not ready
      bus0.flags_valid = 1; bus0.set_flags = 1; bus0.zero = 1; bus0.sign = 1; bus0.overflow = 1;
      bus0.branch_valid = 1; bus0.branch_cond = 3'b111; bus0.branch_target = 36'h111111111;
      bus0.redirect_ready = 0;
      #1;
      n_cmp++;
      if ({bus0.redirect_valid, bus0.stall, bus0.squash} !== 3'b110 || bus0.redirect_pc !== 36'hABCDE0123) begin
        n_mis++; $display("FAIL bp_hold[%0d]: got ctrl=%b pc=%h want 110 pc=abcde0123",
                          i, {bus0.redirect_valid, bus0.stall, bus0.squash}, bus0.redirect_pc);
      end
      step();
    end
    clear_inputs();
    #1;
    n_cmp++;
    if ({bus0.flag_z, bus0.flag_s, bus0.flag_v} !== 3'b000) begin
      n_mis++; $display("FAIL bp_flags: got %b want 000", {bus0.flag_z, bus0.flag_s, bus0.flag_v});
    end
    n_cmp++;
    if (bus0.branch_count !== 32'd1 || bus0.taken_count !== 32'd1) begin
      n_mis++; $display("FAIL bp_cnt: got %0d/%0d want 1/1", bus0.branch_count, bus0.taken_count);
    end
    bus0.redirect_ready = 1;
    #1;
    n_cmp++;
    if (bus0.squash !== 1'b1 || bus0.redirect_pc !== 36'hABCDE0123) begin
      n_mis++; $display("FAIL bp_squash: got sq=%b pc=%h want 1 abcde0123", bus0.squash, bus0.redirect_pc);
    end
    step();
    #1;
    n_cmp++;
    if ({bus0.redirect_valid, bus0.stall, bus0.squash} !== 3'b000) begin
      n_mis++; $display("FAIL bp_idle: got %b want 000", {bus0.redirect_valid, bus0.stall, bus0.squash});
    end
    // Ready held while nothing is pending must stay inert
    step();
    n_cmp++;
    if ({bus0.redirect_valid, bus0.stall, bus0.squash} !== 3'b000) begin
      n_mis++; $display("FAIL bp_ready_idle: got %b want 000", {bus0.redirect_valid, bus0.stall, bus0.squash});
    end
    bus0.redirect_ready = 0;
  endtask

  task automatic test_all_codes();
    int taken_exp;
    do_reset();
    taken_exp = 0;
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        logic [2:0] fl;
        logic       exp_t;
        fl = 3'(f);
        exp_t = golden[c][f];
        bus0.flags_valid = 1; bus0.set_flags = 1;
        bus0.zero = fl[2]; bus0.sign = fl[1]; bus0.overflow = fl[0];
        step();
        clear_inputs();
        bus0.branch_valid = 1; bus0.branch_cond = 3'(c); bus0.branch_target = 36'(c * 8 + f);
        step();
        clear_inputs();
        #1;
        n_cmp++;
        if (bus0.redirect_valid !== exp_t) begin
          n_mis++; $display("FAIL cond_%0d_flags_%b: got taken=%b want %b", c, fl, bus0.redirect_valid, exp_t);
        end
        if (exp_t) taken_exp++;
        if (bus0.redirect_valid === 1'b1) begin
          bus0.redirect_ready = 1;
          step();
          bus0.redirect_ready = 0;
        end
      end
    end
    #1;
    n_cmp++;
    if (bus0.branch_count !== 32'd64 || bus0.taken_count !== 32'd36 || taken_exp != 36) begin
      n_mis++; $display("FAIL sweep_cnt: got %0d/%0d want 64/36", bus0.branch_count, bus0.taken_count);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      bus1.branch_valid = 1; bus1.branch_cond = 3'b111; bus1.branch_target = 36'h10;
      step();
      clear_inputs();
      bus1.redirect_ready = 1;
      step();
      bus1.redirect_ready = 0;
      if (i == 15) begin
        n_cmp++;
        if (bus1.branch_count !== 4'd15 || bus1.taken_count !== 4'd15) begin
          n_mis++; $display("FAIL wrap_15: got %0d/%0d want 15/15", bus1.branch_count, bus1.taken_count);
        end
      end
    end
    #1;
    n_cmp++;
    if (bus1.branch_count !== 4'd0 || bus1.taken_count !== 4'd0 || bus1.redirect_valid !== 1'b0) begin
      n_mis++; $display("FAIL wrap_16: got %0d/%0d rv=%b want 0/0 rv=0",
                        bus1.branch_count, bus1.taken_count, bus1.redirect_valid);
    end
  endtask

  task automatic test_reset_mid_redirect();
    do_reset();
    bus0.branch_valid = 1; bus0.branch_cond = 3'b111; bus0.branch_target = 36'h0000005A5;
    step();
    clear_inputs();
    #1;
    n_cmp++;
    if (bus0.redirect_valid !== 1'b1) begin
      n_mis++; $display("FAIL rmr_enter: got rv=%b want 1", bus0.redirect_valid);
    end
    rst = 1;
    bus0.redirect_ready = 1;
    #1;
    n_cmp++;
    if (bus0.squash !== 1'b0) begin
      n_mis++; $display("FAIL rmr_squash: got %b want 0", bus0.squash);
    end
    step();
    rst = 0;
    bus0.redirect_ready = 0;
    #1;
    n_cmp++;
    if ({bus0.redirect_valid, bus0.stall, bus0.squash} !== 3'b000 || bus0.redirect_pc !== 36'h0) begin
      n_mis++; $display("FAIL rmr_idle: got ctrl=%b pc=%h want 000 pc=0",
                        {bus0.redirect_valid, bus0.stall, bus0.squash}, bus0.redirect_pc);
    end
    n_cmp++;
    if (bus0.branch_count !== 32'd0 || bus0.taken_count !== 32'd0) begin
      n_mis++; $display("FAIL rmr_cnt: got %0d/%0d want 0/0", bus0.branch_count, bus0.taken_count);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_bypass();
    test_not_taken();
    test_backpressure();
    test_all_codes();
    test_wrap();
    test_reset_mid_redirect();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/scalar_branch_unit.md
# scalar_branch_unit

Consumes the zero/sign/overflow flags produced by the scalar execute stage, holds them in an architectural flag register, and resolves conditional branches against them. Sits beside scalar execute. Front end predicts not-taken; a taken branch raises a redirect to fetch over a valid/ready handshake, stalls issue until fetch accepts it, then pulses a squash for wrong-path instructions. Also keeps branch/taken statistics counters.

## Interface
- `ADDR_W`, default 36, PC/target width.
- `CNT_W`, default 32, statistics counter width.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `flags_valid`  in  1  execute result valid this cycle.
- `set_flags`  in  1  instruction writes flags (qualified by `flags_valid`).
- `zero`, `sign`, `overflow`  in  1 each  flags from execute.
- `branch_valid`  in  1  branch instruction in execute this cycle.
- `branch_cond`  in  3  condition code.
- `branch_target`  in  ADDR_W  resolved target.
- `redirect_valid`  out  1  redirect pending.
- `redirect_pc`  out  ADDR_W  redirect address.
- `redirect_ready`  in  1  fetch accepts redirect.
- `stall`  out  1  hold issue/execute.
- `squash`  out  1  one-cycle flush of younger instructions.
- `flag_z`, `flag_s`, `flag_v`  out  1 each  architectural flags.
- `branch_count`, `taken_count`  out  CNT_W each  statistics.

## Operation
- Flag register: when `flags_valid && set_flags` in IDLE, load Z/S/V next edge. Ignored in REDIRECT (wrong path).
- Effective flags for evaluation: incoming flags if `flags_valid && set_flags` same cycle (older instruction, bypass), else registered flags.
- Condition codes: 000 NE (!Z); 001 EQ (Z); 010 GT (!Z && S==V); 011 LT (S!=V); 100 GE (S==V); 101 LE (Z || S!=V); 110 OV (V); 111 ALWAYS.
- FSM, two states:
  - IDLE: `branch_valid` and condition true -> latch `branch_target` into `redirect_pc`, go REDIRECT. Condition false -> stay, no output.
  - REDIRECT: `redirect_valid=1`, `stall=1`; `branch_valid` ignored (not counted). On `redirect_valid && redirect_ready` -> IDLE, `squash=1` that same cycle.
- `redirect_pc` stable while `redirect_valid` high.
- Counters: `branch_count` +1 per accepted branch in IDLE; `taken_count` +1 per taken. Wrap modulo 2^CNT_W.

## Timing
- Reset values: state IDLE, all flags 0, `redirect_valid` 0, `redirect_pc` 0, `stall` 0, `squash` 0, both counters 0.
- Branch in cycle N taken -> `redirect_valid`/`stall` high from N+1; earliest handshake N+1, `squash` high N+1, IDLE at N+2.
- Flag write in cycle N visible on `flag_*` at N+1; bypassed to a branch in N.
- `stall`, `redirect_valid` are registered state decodes; `squash` is combinational from handshake.
- `redirect_ready` while not valid: no effect.
- Reset asserted mid-REDIRECT: next edge forces IDLE and reset values; no squash.

## Structure
- Shared package: `cond_e` enum for the eight condition codes, `bru_state_e` (IDLE, REDIRECT), `ADDR_W` default constant.
- One sub-module: `branch_cond_eval` (combinational; cond, Z, S, V -> taken). Flag register, FSM, counters in top.

## Test plan
- Reset: after `rst` high one cycle -> all outputs 0, state IDLE.
- Bypass: cycle N `set_flags` with Z=1 and BEQ (001), target 0x000001000 -> `redirect_valid` N+1, `redirect_pc`=0x000001000; `flag_z`=1 at N+1.
- Not taken: flags Z=0 S=1 V=0, GE (100) -> no redirect; `branch_count`=1, `taken_count`=0.
- Backpressure: taken branch, `redirect_ready` low 3 cycles -> `stall`/`redirect_valid` held, `redirect_pc` stable, flag writes and new branches ignored; ready high -> `squash` one cycle, IDLE next.
- All codes: sweep 8 conds x 8 flag combos -> `taken_count` matches golden table (LT with S=1 V=1 not taken, LE with Z=1 taken).
- Counter wrap (CNT_W=4): 16 taken branches -> both counters return to 0; reset during REDIRECT -> IDLE, no squash.
